// File: rtl/commit_trace_buffer_if.sv
// Commit-trace tap and debug read port shared by the CPU side and the trace buffer.
interface commit_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 32,
  parameter int TS_W   = 16
);
  localparam int ENTRY_W = 2 + TS_W + 5 + 2 * DATA_W + DM_AW;

  logic [31:0]        pc;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               dm_we;
  logic [DM_AW-1:0]   dm_addr;
  logic [DATA_W-1:0]  dm_wdata;
  logic               rd_req;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_entry;

  modport master (
    output pc, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, rd_req,
    input  rd_valid, rd_entry
  );

  modport slave (
    input  pc, rf_we, rf_waddr, rf_wdata, dm_we, dm_addr, dm_wdata, rd_req,
    output rd_valid, rd_entry
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Timestamped commit-trace buffer for the single-cycle MIPS CPU: captures register-file
// writes and stores, with stop-when-full, circular and PC-triggered post-capture modes.
module commit_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int PCNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [1:0]               mode,
  input  logic [31:0]              trig_pc,
  input  logic [PCNT_W-1:0]        post_cnt,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [1:0]               state
);
  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 2 + TS_W + 5 + 2 * DATA_W + DM_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [PCNT_W-1:0]   post_q, post_d, post_eff;
  logic [TS_W-1:0]     ts;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  entry;
  logic [AW-1:0]       wptr, rptr;
  logic [AW:0]         cnt;
  logic                event_c, trig_hit, push, pop, is_full, circ, mem_we;

  assign event_c  = bus.rf_we | bus.dm_we;
  assign trig_hit = (state_q == ARMED) && (bus.pc == trig_pc);
  assign push     = en && !clr && event_c && ((state_q == CAPTURE) || trig_hit);
  assign pop      = bus.rd_req && (cnt != '0);
  assign is_full  = (cnt == (AW+1)'(DEPTH));
  assign circ     = (mode_q == 2'd1);
  assign post_eff = (post_cnt == '0) ? PCNT_W'(1) : post_cnt;
  assign mem_we   = push && (!is_full || pop || circ);

  assign entry = {bus.rf_we, bus.dm_we, ts,
                  {5{bus.rf_we}} & bus.rf_waddr,
                  {DATA_W{bus.rf_we}} & bus.rf_wdata,
                  {DM_AW{bus.dm_we}} & bus.dm_addr,
                  {DATA_W{bus.dm_we}} & bus.dm_wdata};

  // The trigger cycle's own event counts toward the post-trigger budget.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = (mode == 2'd2) ? ARMED : CAPTURE;
        ARMED: begin
          if (!en) begin
            state_d = IDLE;
          end else if (trig_hit) begin
            post_d  = post_eff - PCNT_W'(event_c);
            state_d = (post_eff == PCNT_W'(event_c)) ? FROZEN : CAPTURE;
          end
        end
        CAPTURE: begin
          if (!en) begin
            state_d = IDLE;
          end else if (mode_q == 2'd2 && push) begin
            post_d = post_q - PCNT_W'(1);
            if (post_q == PCNT_W'(1)) state_d = FROZEN;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      post_q       <= '0;
      ts           <= '0;
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      overflow     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_entry <= '0;
    end else begin
      ts           <= ts + 1'b1;
      state_q      <= state_d;
      post_q       <= post_d;
      bus.rd_valid <= 1'b0;
      if (state_q == IDLE && en && !clr) mode_q <= (mode == 2'd3) ? 2'd0 : mode;
      if (clr) begin
        wptr     <= '0;
        rptr     <= '0;
        cnt      <= '0;
        overflow <= 1'b0;
      end else begin
        if (pop) begin
          bus.rd_valid <= 1'b1;
          bus.rd_entry <= mem[rptr];
        end
        // A pop in the same cycle always makes room, so push+pop never overflows.
        if (push && pop) begin
          wptr <= wptr + 1'b1;
          rptr <= rptr + 1'b1;
        end else if (push) begin
          if (!is_full) begin
            wptr <= wptr + 1'b1;
            cnt  <= cnt + 1'b1;
          end else if (circ) begin
            wptr     <= wptr + 1'b1;
            rptr     <= rptr + 1'b1;
            overflow <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (pop) begin
          rptr <= rptr + 1'b1;
          cnt  <= cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr] <= entry;
  end

  assign count = cnt;
  assign full  = is_full;
  assign empty = (cnt == '0);
  assign state = state_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer; a second instance with TS_W=4 shares the stimulus.
module tb_commit_trace_buffer;
  localparam int DATA_W = 32;
  localparam int DM_AW  = 32;
  localparam int TS_W   = 16;
  localparam int PCNT_W = 8;
  localparam int EW     = 2 + TS_W + 5 + 2 * DATA_W + DM_AW;
  localparam int EW4    = 2 + 4 + 5 + 2 * DATA_W + DM_AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, clr;
  logic [1:0]        mode;
  logic [31:0]       trig_pc;
  logic [PCNT_W-1:0] post_cnt;
  logic [4:0]        count, count4;
  logic              full, empty, overflow, full4, empty4, overflow4;
  logic [1:0]        state, state4;
  int                vectors = 0;
  int                miscompares = 0;

  commit_trace_buffer_if #(.DATA_W(DATA_W), .DM_AW(DM_AW), .TS_W(TS_W)) bus ();
  commit_trace_buffer_if #(.DATA_W(DATA_W), .DM_AW(DM_AW), .TS_W(4))    bus4 ();

  assign bus4.pc       = bus.pc;
  assign bus4.rf_we    = bus.rf_we;
  assign bus4.rf_waddr = bus.rf_waddr;
  assign bus4.rf_wdata = bus.rf_wdata;
  assign bus4.dm_we    = bus.dm_we;
  assign bus4.dm_addr  = bus.dm_addr;
  assign bus4.dm_wdata = bus.dm_wdata;
  assign bus4.rd_req   = bus.rd_req;

  commit_trace_buffer #(.DATA_W(DATA_W), .DM_AW(DM_AW), .DEPTH(16), .TS_W(TS_W), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .bus(bus), .count(count), .full(full), .empty(empty), .overflow(overflow), .state(state));

  commit_trace_buffer #(.DATA_W(DATA_W), .DM_AW(DM_AW), .DEPTH(16), .TS_W(4), .PCNT_W(PCNT_W)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .bus(bus4), .count(count4), .full(full4), .empty(empty4), .overflow(overflow4), .state(state4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic rw, input logic [4:0] ra, input logic [31:0] rd,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd);
    bus.rf_we = rw; bus.rf_waddr = ra; bus.rf_wdata = rd;
    bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; clr = 1'b0; bus.rd_req = 1'b0; bus.pc = '0;
    set_ev(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic pop(output logic v, output logic [EW-1:0] e, output logic [EW4-1:0] e4);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    v = bus.rd_valid; e = bus.rd_entry; e4 = bus4.rd_entry;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %0b exp 0", full); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %0b exp 1", empty); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", state); end
    vectors++; if (bus.rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %0b exp 0", bus.rd_valid); end
    vectors++; if (bus.rd_entry !== '0) begin miscompares++; $display("FAIL reset_rd_entry got %0h exp 0", bus.rd_entry); end
  endtask

  task automatic test_fifo_stop;
    logic v; logic [EW-1:0] e, exp; logic [EW4-1:0] e4;
    do_reset(); mode = 2'd0; en = 1'b1; tick();
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL fifo_state got %0d exp 2", state); end
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0) set_ev(1, 5'(i + 1), 32'(i + 1), 0, 0, 0);
      else            set_ev(0, 0, 0, 1, 32'h100 + 32'(i), 32'(i + 1));
      tick();
    end
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fifo_count got %0d exp 16", count); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fifo_full got %0b exp 1", full); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fifo_overflow got %0b exp 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      pop(v, e, e4);
      if (i % 2 == 0) exp = {1'b1, 1'b0, 16'(i + 1), 5'(i + 1), 32'(i + 1), 32'h0, 32'h0};
      else            exp = {1'b0, 1'b1, 16'(i + 1), 5'd0, 32'h0, 32'h100 + 32'(i), 32'(i + 1)};
      vectors++; if (v !== 1'b1 || e !== exp) begin
        miscompares++; $display("FAIL fifo_pop%0d got v=%0b %0h exp v=1 %0h", i, v, e, exp);
      end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fifo_empty got %0b exp 1", empty); end
    pop(v, e, e4);
    vectors++; if (v !== 1'b0) begin miscompares++; $display("FAIL fifo_pop_empty got %0b exp 0", v); end
    vectors++; if (count !== 5'd0 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL fifo_pop_empty_flags got count=%0d ovf=%0b exp 0 1", count, overflow);
    end
  endtask

  task automatic test_circular;
    logic v; logic [EW-1:0] e; logic [EW4-1:0] e4;
    do_reset(); mode = 2'd1; en = 1'b1; tick();
    for (int i = 1; i <= 16; i++) begin set_ev(1, 3, 32'(i), 0, 0, 0); tick(); end
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (full !== 1'b1 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL circ_fill got full=%0b ovf=%0b exp 1 0", full, overflow);
    end
    set_ev(1, 3, 32'd17, 0, 0, 0); bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_entry[95:64] !== 32'd1) begin
      miscompares++; $display("FAIL circ_pushpop_data got v=%0b %0d exp v=1 1", bus.rd_valid, bus.rd_entry[95:64]);
    end
    vectors++; if (count !== 5'd16 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL circ_pushpop_flags got count=%0d ovf=%0b exp 16 0", count, overflow);
    end
    for (int i = 18; i <= 20; i++) begin set_ev(1, 3, 32'(i), 0, 0, 0); tick(); end
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (count !== 5'd16 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL circ_overwrite got count=%0d ovf=%0b exp 16 1", count, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      pop(v, e, e4);
      vectors++; if (v !== 1'b1 || e[95:64] !== 32'(5 + i)) begin
        miscompares++; $display("FAIL circ_pop%0d got v=%0b %0d exp v=1 %0d", i, v, e[95:64], 5 + i);
      end
    end
  endtask

  task automatic test_triggered;
    logic v; logic [EW-1:0] e; logic [EW4-1:0] e4;
    do_reset(); mode = 2'd2; trig_pc = 32'h10; post_cnt = 8'd3; en = 1'b1; tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL trig_armed got %0d exp 1", state); end
    bus.pc = 32'h4; set_ev(1, 2, 32'hAA, 0, 0, 0); tick();
    vectors++; if (state !== 2'd1 || count !== 5'd0) begin
      miscompares++; $display("FAIL trig_pre got state=%0d count=%0d exp 1 0", state, count);
    end
    bus.pc = 32'h10; set_ev(1, 2, 32'd1, 0, 0, 0); tick();
    vectors++; if (state !== 2'd2 || count !== 5'd1) begin
      miscompares++; $display("FAIL trig_hit got state=%0d count=%0d exp 2 1", state, count);
    end
    bus.pc = 32'h14; set_ev(1, 2, 32'd2, 0, 0, 0); tick();
    bus.pc = 32'h18; set_ev(0, 0, 0, 0, 0, 0); tick();
    vectors++; if (state !== 2'd2 || count !== 5'd2) begin
      miscompares++; $display("FAIL trig_post got state=%0d count=%0d exp 2 2", state, count);
    end
    bus.pc = 32'h1c; set_ev(1, 2, 32'd3, 0, 0, 0); tick();
    vectors++; if (state !== 2'd3 || count !== 5'd3) begin
      miscompares++; $display("FAIL trig_frozen got state=%0d count=%0d exp 3 3", state, count);
    end
    bus.pc = 32'h10; set_ev(1, 2, 32'd4, 1, 32'h8, 32'h9); tick();
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (state !== 2'd3 || count !== 5'd3) begin
      miscompares++; $display("FAIL trig_after got state=%0d count=%0d exp 3 3", state, count);
    end
    for (int i = 1; i <= 3; i++) begin
      pop(v, e, e4);
      vectors++; if (v !== 1'b1 || e[95:64] !== 32'(i)) begin
        miscompares++; $display("FAIL trig_pop%0d got v=%0b %0d exp v=1 %0d", i, v, e[95:64], i);
      end
    end
    clr = 1'b1; tick(); clr = 1'b0;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL trig_clr got %0d exp 0", state); end
    tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL trig_rearm got %0d exp 1", state); end
  endtask

  task automatic test_dual_channel;
    logic v; logic [EW-1:0] e, exp; logic [EW4-1:0] e4;
    do_reset(); mode = 2'd0; en = 1'b1; tick();
    set_ev(1, 5'd8, 32'h5, 1, 32'h40, 32'hA); tick();
    set_ev(1, 5'd9, 32'h77, 0, 32'h44, 32'hBB); tick();
    set_ev(1, 5'd0, 32'h33, 0, 0, 0); tick();
    set_ev(0, 0, 0, 0, 0, 0);
    pop(v, e, e4); exp = {1'b1, 1'b1, 16'd1, 5'd8, 32'h5, 32'h40, 32'hA};
    vectors++; if (v !== 1'b1 || e !== exp) begin miscompares++; $display("FAIL dual_both got %0h exp %0h", e, exp); end
    pop(v, e, e4); exp = {1'b1, 1'b0, 16'd2, 5'd9, 32'h77, 32'h0, 32'h0};
    vectors++; if (v !== 1'b1 || e !== exp) begin miscompares++; $display("FAIL dual_rf_only got %0h exp %0h", e, exp); end
    pop(v, e, e4); exp = {1'b1, 1'b0, 16'd3, 5'd0, 32'h33, 32'h0, 32'h0};
    vectors++; if (v !== 1'b1 || e !== exp) begin miscompares++; $display("FAIL dual_r0 got %0h exp %0h", e, exp); end
  endtask

  task automatic test_reset_midread;
    do_reset(); mode = 2'd0; en = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin set_ev(1, 4, 32'(i), 0, 0, 0); tick(); end
    set_ev(0, 0, 0, 0, 0, 0);
    bus.rd_req = 1'b1; tick(); rst = 1'b1; tick(); rst = 1'b0; bus.rd_req = 1'b0;
    vectors++; if (count !== 5'd0 || empty !== 1'b1 || bus.rd_valid !== 1'b0 || state !== 2'd0) begin
      miscompares++; $display("FAIL rst_midread got count=%0d empty=%0b v=%0b state=%0d exp 0 1 0 0",
                              count, empty, bus.rd_valid, state);
    end
    tick();
    for (int i = 0; i < 3; i++) begin set_ev(1, 4, 32'(i), 0, 0, 0); tick(); end
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL clr_setup got %0d exp 3", count); end
    clr = 1'b1; bus.rd_req = 1'b1; tick(); clr = 1'b0; bus.rd_req = 1'b0;
    vectors++; if (count !== 5'd0 || empty !== 1'b1 || bus.rd_valid !== 1'b0 || state !== 2'd0) begin
      miscompares++; $display("FAIL clr_pop got count=%0d empty=%0b v=%0b state=%0d exp 0 1 0 0",
                              count, empty, bus.rd_valid, state);
    end
    tick();
    vectors++; if (bus.rd_valid !== 1'b0 || state !== 2'd2) begin
      miscompares++; $display("FAIL clr_after got v=%0b state=%0d exp 0 2", bus.rd_valid, state);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(); mode = 2'd0; en = 1'b1; tick();
    for (int i = 1; i <= 16; i++) begin set_ev(1, 6, 32'(i), 0, 0, 0); tick(); end
    set_ev(1, 6, 32'd17, 0, 0, 0); bus.rd_req = 1'b1; tick();
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_entry[95:64] !== 32'd1 || count !== 5'd16 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL b2b_full_pushpop got v=%0b d=%0d count=%0d ovf=%0b exp 1 1 16 0",
                              bus.rd_valid, bus.rd_entry[95:64], count, overflow);
    end
    for (int k = 0; k < 16; k++) begin
      tick();
      vectors++; if (bus.rd_valid !== 1'b1 || bus.rd_entry[95:64] !== 32'(k + 2)) begin
        miscompares++; $display("FAIL b2b_pop%0d got v=%0b %0d exp v=1 %0d", k, bus.rd_valid, bus.rd_entry[95:64], k + 2);
      end
    end
    bus.rd_req = 1'b0; tick();
    vectors++; if (bus.rd_valid !== 1'b0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL b2b_end got v=%0b empty=%0b exp 0 1", bus.rd_valid, empty);
    end
  endtask

  task automatic test_ts_wrap;
    logic v; logic [EW-1:0] e; logic [EW4-1:0] e4;
    do_reset(); mode = 2'd0; en = 1'b1; tick();
    vectors++; if (state4 !== 2'd2) begin miscompares++; $display("FAIL ts4_state got %0d exp 2", state4); end
    for (int i = 0; i < 18; i++) begin
      set_ev(1, 7, 32'(i), 0, 0, 0); tick();
      vectors++; if (count4 !== 5'((i + 1 > 16) ? 16 : i + 1)) begin
        miscompares++; $display("FAIL ts4_count%0d got %0d exp %0d", i, count4, (i + 1 > 16) ? 16 : i + 1);
      end
    end
    set_ev(0, 0, 0, 0, 0, 0);
    vectors++; if (full4 !== 1'b1 || overflow4 !== 1'b1) begin
      miscompares++; $display("FAIL ts4_flags got full=%0b ovf=%0b exp 1 1", full4, overflow4);
    end
    for (int i = 0; i < 16; i++) begin
      pop(v, e, e4);
      vectors++; if (e4[104:101] !== 4'((i + 1) % 16) || e4[95:64] !== 32'(i)) begin
        miscompares++; $display("FAIL ts4_pop%0d got ts=%0d d=%0d exp ts=%0d d=%0d", i, e4[104:101], e4[95:64], (i + 1) % 16, i);
      end
    end
    vectors++; if (empty4 !== 1'b1) begin miscompares++; $display("FAIL ts4_empty got %0b exp 1", empty4); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; trig_pc = '0; post_cnt = '0;
    bus.rd_req = 1'b0; bus.pc = '0;
    set_ev(0, 0, 0, 0, 0, 0);
    test_reset();
    test_fifo_stop();
    test_circular();
    test_triggered();
    test_dual_channel();
    test_reset_midread();
    test_back_to_back();
    test_ts_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
